// File: rtl/brownout_pkg.sv
// Shared types and constants for the brownout detector host controller.
package brownout_pkg;
  localparam int TRIP_W = 3;
  localparam logic [TRIP_W-1:0] TRIP_RST_DEF = 3'b111;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MONITOR = 2'd2
  } bo_state_e;
endpackage

// File: rtl/bo_sync_filter.sv
// Multi-flop synchronizer followed by a consecutive-sample debounce filter.
module bo_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic async_in,
  output logic filt_out
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign filt_out = r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
    end
  end

  // The filtered value only moves after DEB_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == DEB_LAST) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/brownout_ctrl.sv
// Host-side controller for the brownout macro: enable/settle sequencing,
// trip-code registers, filtered detector inputs, sticky flags and reset request.
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int                SETTLE_CYCLES = 1024,
  parameter int                SYNC_STAGES   = 2,
  parameter int                DEB_CYCLES    = 8,
  parameter logic [TRIP_W-1:0] TRIP_RST      = TRIP_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_wr,
  input  logic [TRIP_W-1:0] cfg_otrip,
  input  logic [TRIP_W-1:0] cfg_vtrip,
  input  logic              irq_clr,
  input  logic              bo_out,
  input  logic              bo_vunder,
  input  logic              bo_timed_out,
  output logic              ena,
  output logic [TRIP_W-1:0] otrip,
  output logic [TRIP_W-1:0] vtrip,
  output logic              ready,
  output logic              bo_live,
  output logic              vunder_live,
  output logic              timed_out_sync,
  output logic              brownout_flag,
  output logic              vunder_flag,
  output logic              irq,
  output logic              sys_rst_req,
  output logic [1:0]        dbg_state
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  bo_state_e               r_state;
  bo_state_e               w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [TRIP_W-1:0]       r_otrip;
  logic [TRIP_W-1:0]       r_vtrip;
  logic [SYNC_STAGES-1:0]  r_to_sync;
  logic                    r_bo_prev;
  logic                    r_vu_prev;
  logic                    r_bo_flag;
  logic                    r_vu_flag;
  logic                    w_filt_clr;
  logic                    w_bo_live;
  logic                    w_vu_live;
  logic                    w_ready;
  logic                    w_bo_set;
  logic                    w_vu_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Dropping cfg_en wins over everything; cfg_wr while on restarts the settle window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (cfg_en) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!cfg_en) begin
          w_state_nxt = ST_OFF;
        end else if (cfg_wr) begin
          w_cnt_nxt = SETTLE_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_MONITOR;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_MONITOR: begin
        if (!cfg_en) begin
          w_state_nxt = ST_OFF;
        end else if (cfg_wr) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_otrip <= TRIP_RST;
      r_vtrip <= TRIP_RST;
    end else if (cfg_wr) begin
      r_otrip <= cfg_otrip;
      r_vtrip <= cfg_vtrip;
    end
  end

  // Filters are cleared on the same edge the FSM enters OFF, so they read 0 throughout OFF.
  assign w_filt_clr = (w_state_nxt == ST_OFF);

  bo_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_filt_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_filt_clr),
    .async_in (bo_out),
    .filt_out (w_bo_live)
  );

  bo_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_filt_vunder (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_filt_clr),
    .async_in (bo_vunder),
    .filt_out (w_vu_live)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_sync <= '0;
    end else begin
      r_to_sync <= {r_to_sync[SYNC_STAGES-2:0], bo_timed_out};
    end
  end

  assign w_ready  = (r_state == ST_MONITOR);
  assign w_bo_set = w_ready & w_bo_live & ~r_bo_prev;
  assign w_vu_set = w_ready & w_vu_live & ~r_vu_prev;

  // A rise seen on the same edge as irq_clr keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bo_prev <= 1'b0;
      r_vu_prev <= 1'b0;
      r_bo_flag <= 1'b0;
      r_vu_flag <= 1'b0;
    end else begin
      r_bo_prev <= w_bo_live;
      r_vu_prev <= w_vu_live;
      r_bo_flag <= w_bo_set | (r_bo_flag & ~irq_clr);
      r_vu_flag <= w_vu_set | (r_vu_flag & ~irq_clr);
    end
  end

  assign ena            = (r_state != ST_OFF);
  assign ready          = w_ready;
  assign otrip          = r_otrip;
  assign vtrip          = r_vtrip;
  assign bo_live        = w_bo_live;
  assign vunder_live    = w_vu_live;
  assign timed_out_sync = r_to_sync[SYNC_STAGES-1];
  assign brownout_flag  = r_bo_flag;
  assign vunder_flag    = r_vu_flag;
  assign irq            = r_bo_flag | r_vu_flag;
  assign sys_rst_req    = w_bo_live & w_ready;
  assign dbg_state      = r_state;
endmodule

// File: tb/tb_brownout_ctrl.sv
// Directed bench for brownout_ctrl with SETTLE_CYCLES=16, SYNC_STAGES=2, DEB_CYCLES=8.
module tb_brownout_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_wr;
  logic [2:0] cfg_otrip;
  logic [2:0] cfg_vtrip;
  logic       irq_clr;
  logic       bo_out;
  logic       bo_vunder;
  logic       bo_timed_out;
  logic       ena;
  logic [2:0] otrip;
  logic [2:0] vtrip;
  logic       ready;
  logic       bo_live;
  logic       vunder_live;
  logic       timed_out_sync;
  logic       brownout_flag;
  logic       vunder_flag;
  logic       irq;
  logic       sys_rst_req;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_MON = 2'd2;

  brownout_ctrl #(
    .SETTLE_CYCLES (16),
    .SYNC_STAGES   (2),
    .DEB_CYCLES    (8),
    .TRIP_RST      (3'b111)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_en         (cfg_en),
    .cfg_wr         (cfg_wr),
    .cfg_otrip      (cfg_otrip),
    .cfg_vtrip      (cfg_vtrip),
    .irq_clr        (irq_clr),
    .bo_out         (bo_out),
    .bo_vunder      (bo_vunder),
    .bo_timed_out   (bo_timed_out),
    .ena            (ena),
    .otrip          (otrip),
    .vtrip          (vtrip),
    .ready          (ready),
    .bo_live        (bo_live),
    .vunder_live    (vunder_live),
    .timed_out_sync (timed_out_sync),
    .brownout_flag  (brownout_flag),
    .vunder_flag    (vunder_flag),
    .irq            (irq),
    .sys_rst_req    (sys_rst_req),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ena"}, 8'(ena), 8'd0);
    chk({tag, "_otrip"}, 8'(otrip), 8'd7);
    chk({tag, "_vtrip"}, 8'(vtrip), 8'd7);
    chk({tag, "_ready"}, 8'(ready), 8'd0);
    chk({tag, "_bo_live"}, 8'(bo_live), 8'd0);
    chk({tag, "_vu_live"}, 8'(vunder_live), 8'd0);
    chk({tag, "_to_sync"}, 8'(timed_out_sync), 8'd0);
    chk({tag, "_bo_flag"}, 8'(brownout_flag), 8'd0);
    chk({tag, "_vu_flag"}, 8'(vunder_flag), 8'd0);
    chk({tag, "_irq"}, 8'(irq), 8'd0);
    chk({tag, "_sysrst"}, 8'(sys_rst_req), 8'd0);
    chk({tag, "_state"}, 8'(dbg_state), 8'(S_OFF));
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_wr = 1'b0; cfg_otrip = 3'b000; cfg_vtrip = 3'b000;
    irq_clr = 1'b0; bo_out = 1'b0; bo_vunder = 1'b0; bo_timed_out = 1'b0;

    // 1: reset, enable, 16-cycle settle window
    step(); step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step(); step();
    chk("idle_state", 8'(dbg_state), 8'(S_OFF));
    cfg_en = 1'b1;
    step();
    chk("en_ena", 8'(ena), 8'd1);
    chk("en_state", 8'(dbg_state), 8'(S_SETTLE));
    for (int n = 2; n <= 16; n++) begin
      step();
      chk($sformatf("settle_ready_%0d", n), 8'(ready), 8'd0);
      chk($sformatf("settle_ena_%0d", n), 8'(ena), 8'd1);
    end
    step();
    chk("mon_ready", 8'(ready), 8'd1);
    chk("mon_state", 8'(dbg_state), 8'(S_MON));
    chk("mon_otrip", 8'(otrip), 8'd7);
    chk("mon_vtrip", 8'(vtrip), 8'd7);

    // 2: sustained bo_out in MONITOR
    bo_out = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("bo_live_%0d", n), 8'(bo_live), 8'(n >= 10));
      chk($sformatf("bo_flag_%0d", n), 8'(brownout_flag), 8'(n >= 11));
      chk($sformatf("bo_irq_%0d", n), 8'(irq), 8'(n >= 11));
      chk($sformatf("bo_sysrst_%0d", n), 8'(sys_rst_req), 8'(n >= 10));
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("clr_bo_flag", 8'(brownout_flag), 8'd0);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk($sformatf("clr_hold_flag_%0d", n), 8'(brownout_flag), 8'd0);
      chk($sformatf("clr_hold_live_%0d", n), 8'(bo_live), 8'd1);
    end
    bo_out = 1'b0;
    for (int n = 1; n <= 12; n++) step();
    chk("bo_fall_live", 8'(bo_live), 8'd0);
    chk("bo_fall_sysrst", 8'(sys_rst_req), 8'd0);

    // 4 + settle glitch: trip write in MONITOR, then rewrite mid-SETTLE
    cfg_wr = 1'b1; cfg_otrip = 3'b010; cfg_vtrip = 3'b001;
    step();
    cfg_wr = 1'b0;
    chk("wr1_otrip", 8'(otrip), 8'h2);
    chk("wr1_vtrip", 8'(vtrip), 8'h1);
    chk("wr1_ready", 8'(ready), 8'd0);
    chk("wr1_state", 8'(dbg_state), 8'(S_SETTLE));
    for (int n = 1; n <= 8; n++) begin
      step();
      chk($sformatf("wr1_settle_%0d", n), 8'(ready), 8'd0);
      chk($sformatf("wr1_otrip_hold_%0d", n), 8'(otrip), 8'h2);
    end
    cfg_wr = 1'b1; cfg_otrip = 3'b101; cfg_vtrip = 3'b011;
    bo_out = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      cfg_wr = 1'b0;
      if (n == 12) bo_out = 1'b0;
      chk($sformatf("wr2_ready_%0d", n), 8'(ready), 8'(n >= 17));
      chk($sformatf("sg_live_%0d", n), 8'(bo_live), 8'(n >= 10 && n < 22));
      chk($sformatf("sg_sysrst_%0d", n), 8'(sys_rst_req), 8'(n >= 17 && n < 22));
      chk($sformatf("sg_flag_%0d", n), 8'(brownout_flag), 8'd0);
    end
    chk("wr2_otrip", 8'(otrip), 8'h5);
    chk("wr2_vtrip", 8'(vtrip), 8'h3);

    // 3: 7-cycle glitch in MONITOR is rejected
    bo_out = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      step();
      if (n == 7) bo_out = 1'b0;
      chk($sformatf("gl7_live_%0d", n), 8'(bo_live), 8'd0);
    end
    chk("gl7_irq", 8'(irq), 8'd0);

    // 5: irq_clr on the same edge as the vunder flag set
    bo_vunder = 1'b1;
    for (int n = 1; n <= 10; n++) step();
    chk("vu_live_10", 8'(vunder_live), 8'd1);
    chk("vu_flag_10", 8'(vunder_flag), 8'd0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("vu_flag_set_wins", 8'(vunder_flag), 8'd1);
    chk("vu_irq", 8'(irq), 8'd1);
    chk("vu_bo_flag", 8'(brownout_flag), 8'd0);
    chk("vu_no_sysrst", 8'(sys_rst_req), 8'd0);
    bo_timed_out = 1'b1;
    step();
    chk("to_sync_1", 8'(timed_out_sync), 8'd0);
    step();
    chk("to_sync_2", 8'(timed_out_sync), 8'd1);
    bo_timed_out = 1'b0;
    cfg_en = 1'b0;
    step();
    chk("off_ena", 8'(ena), 8'd0);
    chk("off_ready", 8'(ready), 8'd0);
    chk("off_vu_live", 8'(vunder_live), 8'd0);
    chk("off_bo_live", 8'(bo_live), 8'd0);
    chk("off_vu_flag", 8'(vunder_flag), 8'd1);
    chk("off_irq", 8'(irq), 8'd1);
    step();
    chk("off_to_sync", 8'(timed_out_sync), 8'd0);
    chk("off_vu_live_hold", 8'(vunder_live), 8'd0);
    cfg_wr = 1'b1; cfg_otrip = 3'b100; cfg_vtrip = 3'b110;
    step();
    cfg_wr = 1'b0;
    chk("offwr_otrip", 8'(otrip), 8'h4);
    chk("offwr_vtrip", 8'(vtrip), 8'h6);
    chk("offwr_state", 8'(dbg_state), 8'(S_OFF));
    chk("offwr_ena", 8'(ena), 8'd0);
    bo_vunder = 1'b0;

    // 6: asynchronous reset in the middle of SETTLE
    cfg_en = 1'b1;
    for (int n = 1; n <= 5; n++) step();
    chk("pre_rst_state", 8'(dbg_state), 8'(S_SETTLE));
    chk("pre_rst_irq", 8'(irq), 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    cfg_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 8'(dbg_state), 8'(S_OFF));
    chk("post_rst_ena", 8'(ena), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
